ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the banked byte RAM (8 banks x 256 B, 11-bit byte address, 32-bit big-endian word).
//  Port A is instruction fetch; port B is load/store. Grants one request at a time, sequences the RAM enable/write/read cycle,
//  and returns read data or a write ack to the granted port. Rejects writes the RAM would silently drop (byte offset > 252).
// PARAMETERS
//  ADDR_W  11  byte address width; bits [ADDR_W-1:8] select the bank, [7:0] the byte offset
//  DATA_W  32  word width
//  RD_LAT  1   RAM read latency in cycles (>=1); sets the length of WAIT
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  a_valid      in   1       port A request valid
//  a_ready      out  1       port A request accepted this cycle
//  a_we         in   1       port A write (1) / read (0)
//  a_addr       in   ADDR_W  port A byte address
//  a_wdata      in   DATA_W  port A write data
//  a_rvalid     out  1       port A response valid (1-cycle pulse)
//  a_rdata      out  DATA_W  port A read data (0 for writes)
//  a_err        out  1       port A response error flag, qualified by a_rvalid
//  b_*          -    -       identical set for port B (b_valid ... b_err)
//  ram_en       out  1       RAM enable (active for exactly one cycle per issued access)
//  ram_we       out  1       RAM write enable
//  ram_addr     out  ADDR_W  RAM byte address
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data, valid RD_LAT cycles after the ram_en cycle
//  busy         out  1       high in every state except IDLE
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> WAIT (RD_LAT cycles, down-counter) -> RESP -> IDLE. One request in flight at a time, no pipelining.
//  - IDLE: x_ready is combinational and asserted only for the granted port, and only when that port's x_valid is high.
//    On the accept edge, latch we, addr and wdata, and record the granted port. Requesters may drop x_valid after acceptance.
//  - ISSUE (1 cycle): drive ram_en=1, ram_we, ram_addr and ram_wdata from the latches.
//    Error case: a write with addr[7:0] > 252 drives ram_en=0 and sets the error latch. Reads are never errors;
//    the RAM zero-pads reads at offsets 253-255, and that data is returned unchanged.
//  - WAIT: load the counter with RD_LAT-1 and count down to 0. On the final WAIT cycle, capture ram_rdata into the rdata
//    register for reads, or load 0 for writes.
//  - RESP (1 cycle): pulse x_rvalid=1 for the granted port only. x_rdata and x_err are valid in this cycle and hold their
//    values until the next RESP.
//  - Latency: accept edge to x_rvalid is 2+RD_LAT cycles (3 at default). Minimum spacing between accepts is 3+RD_LAT cycles.
//  - ram_* outputs are 0 in every state except ISSUE.
//  - A and B responses are never valid in the same cycle. There is no backpressure on responses; requesters must sink them.
//  - Reset (any state, including mid-access): state=IDLE; all outputs 0 (x_ready, x_rvalid, x_rdata, x_err, ram_*, busy);
//    counter=0; last_grant=B. An aborted access produces no response. A write already in ISSUE on the reset edge has
//    already reached the RAM.
//  - Address/width: no arithmetic on addresses; the counter is clog2(RD_LAT)+1 bits wide.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//   - When both ports are valid in IDLE, grant the port not named by last_grant.
//   - last_grant updates on every accept.
//   - When only one port is valid, that port is granted.
//  ARB_ROUND_ROBIN_EN undefined:
//   - Fixed priority: A always wins. B is granted only when a_valid=0.
//   - last_grant is unused (tied off).
// TESTING
//  1. Reset, then A writes 0xDEADBEEF @0x104 -> ram_en/ram_we high exactly 1 cycle, a_rvalid 3 cycles after accept, a_err=0, a_rdata=0.
//  2. B reads @0x104 after test 1 -> b_rvalid 3 cycles after accept, b_rdata=0xDEADBEEF; a_rvalid stays 0.
//  3. A and B valid on the same cycle for 4 back-to-back requests each:
//     - RR_EN: grants alternate A,B,A,B...
//     - without RR_EN: all 4 A requests are served before any B request.
//  4. A writes @0x2FD (offset 253) -> ram_en stays 0, a_rvalid with a_err=1; a following read @0x2FC returns the old word unchanged.
//  5. Assert rst during WAIT of a B read -> next cycle busy=0, no b_rvalid; a new A read is then accepted and completes normally.
//  6. RD_LAT=3 build, A read -> a_rvalid 5 cycles after accept, data matches the RAM model.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer for the banked byte RAM: one access in flight, IDLE->ISSUE->WAIT->RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; without it port A has fixed priority over port B.
module ram_port_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int              CNT_W      = $clog2(RD_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RD_LAT - 1);
    localparam logic [7:0]      MAX_WR_OFF = 8'd252;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                a_rvalid_q, a_rvalid_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic                a_err_q, a_err_d;
    logic                b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                b_err_q, b_err_d;

    logic                grant_a, grant_b;
    logic                in_idle, accept, sel_b;
    logic                req_we, req_err;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W-1:0]   resp_data;

`ifdef ARB_ROUND_ROBIN_EN
    // last_grant: 0 = A, 1 = B; the port not named wins a tie.
    logic last_grant_q, last_grant_d;
    assign grant_a = a_valid && (!b_valid || last_grant_q);
    assign grant_b = b_valid && (!a_valid || !last_grant_q);
`else
    assign grant_a = a_valid;
    assign grant_b = b_valid && !a_valid;
`endif

    // Request handshake: a request transfers on a rising edge where x_valid && x_ready. x_ready is
    // only raised in IDLE for the granted port; the response is a 1-cycle x_rvalid pulse that cannot stall.
    assign in_idle = (state_q == ST_IDLE) && !rst;
    assign a_ready = in_idle && grant_a;
    assign b_ready = in_idle && grant_b;
    assign accept  = a_ready || b_ready;
    assign sel_b   = b_ready;

    assign req_we    = sel_b ? b_we    : a_we;
    assign req_addr  = sel_b ? b_addr  : a_addr;
    assign req_wdata = sel_b ? b_wdata : a_wdata;
    // Writes past offset 252 would spill out of the bank and are dropped by the RAM, so flag them here.
    assign req_err   = req_we && (req_addr[7:0] > MAX_WR_OFF);

    assign resp_data = we_q ? '0 : ram_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        we_d        = we_q;
        err_d       = err_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        a_rvalid_d  = 1'b0;
        a_rdata_d   = a_rdata_q;
        a_err_d     = a_err_q;
        b_rvalid_d  = 1'b0;
        b_rdata_d   = b_rdata_q;
        b_err_d     = b_err_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_ISSUE;
                    port_d      = sel_b;
                    we_d        = req_we;
                    err_d       = req_err;
                    ram_en_d    = !req_err;
                    ram_we_d    = req_we;
                    ram_addr_d  = req_addr;
                    ram_wdata_d = req_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = sel_b;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_LOAD;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (port_q) begin
                        b_rvalid_d = 1'b1;
                        b_rdata_d  = resp_data;
                        b_err_d    = err_q;
                    end else begin
                        a_rvalid_d = 1'b1;
                        a_rdata_d  = resp_data;
                        a_err_d    = err_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            a_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            a_err_q     <= 1'b0;
            b_rvalid_q  <= 1'b0;
            b_rdata_q   <= '0;
            b_err_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            we_q        <= we_d;
            err_q       <= err_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            a_rvalid_q  <= a_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            a_err_q     <= a_err_d;
            b_rvalid_q  <= b_rvalid_d;
            b_rdata_q   <= b_rdata_d;
            b_err_q     <= b_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign a_rvalid  = a_rvalid_q;
    assign a_rdata   = a_rdata_q;
    assign a_err     = a_err_q;
    assign b_rvalid  = b_rvalid_q;
    assign b_rdata   = b_rdata_q;
    assign b_err     = b_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule
